lcd_frame_scheduler: RTL and testbench
======================================

// Module: lcd_frame_scheduler
// PURPOSE
//  Owns the 2x16 character LCD on behalf of the cracker. Two requesters (status, result) each post a
//  full 16-char line; block arbitrates round-robin, stores lines in a 2-line frame buffer, and replays
//  the frame into the LCD nibble driver via its home/writeChar/ready handshake. Sits between core logic and driver.
// PARAMETERS
//  COLS           16      chars per line
//  PAD_CHARS      24      spaces written after line 0 to reach DDRAM 0x40 (line 1 start)
//  HOME_SETTLE    100000  cycles waited after home completes (2 ms @ 50 MHz)
//  REFRESH_CYCLES 50000000 periodic refresh interval (LCD_PERIODIC_REFRESH_EN only)
// PORTS
//  clk            in   1    system clock (50 MHz)
//  rst_n          in   1    asynchronous, active-low reset
//  req0/req1      in   1    line-write request; held high until matching ack
//  sel0/sel1      in   1    target line (0 = top, 1 = bottom)
//  text0/text1    in   128  16 chars; [127:120] = column 0, [7:0] = column 15
//  ack0/ack1      out  1    one-cycle pulse: text latched into frame buffer
//  lcd_ready      in   1    driver idle and accepting a command
//  lcd_char       out  8    char to driver; held stable until lcd_ready returns high
//  lcd_write_char out  1    one-cycle strobe: write lcd_char
//  lcd_home       out  1    one-cycle strobe: cursor home
//  busy           out  1    refresh in progress (state != IDLE)
// BEHAVIOUR
//  Reset: all outputs 0; frame buffer = 32 x 8'h20; dirty = 1 (display blanked after driver init); rr_ptr = 0.
//  FSM: IDLE -> HOME_ISSUE -> HOME_WAIT -> SETTLE -> CHAR_ISSUE -> CHAR_GUARD -> CHAR_WAIT -> (CHAR_ISSUE | IDLE).
//  IDLE: only state accepting requests. Both req high: grant rr_ptr side, rr_ptr flips to other; single
//   req: grant it. Grant = write text into line sel, pulse ack next edge, dirty <= 1. One grant per cycle.
//   Same-line writes from both requesters in consecutive cycles: last grant wins.
//   If no grant this cycle, dirty = 1 and lcd_ready = 1 -> HOME_ISSUE (grant has priority over refresh start).
//  HOME_ISSUE: lcd_home = 1 for exactly one cycle, dirty <= 0, pos <= 0 -> HOME_WAIT.
//  HOME_WAIT: one guard cycle ignoring lcd_ready, then wait lcd_ready = 1 -> SETTLE (counter = HOME_SETTLE-1 down to 0).
//  CHAR_ISSUE: lcd_char = f(pos), lcd_write_char = 1 for one cycle only when lcd_ready = 1; else hold.
//   f(pos): pos 0..15 -> line0[pos]; 16..39 -> 8'h20; 40..55 -> line1[pos-40]. pos is 6 bits, total 56 writes.
//  CHAR_GUARD: one cycle (driver drops ready one edge after strobe) -> CHAR_WAIT.
//  CHAR_WAIT: lcd_ready = 1 -> pos == 55 ? IDLE : pos+1, CHAR_ISSUE. lcd_char unchanged throughout.
//  Requests arriving mid-refresh wait (no ack); frame never changes during a refresh, so no tearing.
//  lcd_home and lcd_write_char never high in same cycle; never strobe while lcd_ready = 0.
//  rst_n low mid-refresh: immediate return to reset values; pending requester must keep req asserted.
// CONFIGURATION
//  LCD_PERIODIC_REFRESH_EN defined: free-running counter sets dirty every REFRESH_CYCLES cycles
//   (recovers from LCD glitches/ESD); counter reloads at wrap, independent of FSM state.
//  Undefined: counter absent; refresh only after a granted write or reset.
// STRUCTURE
//  Shared package lcd_pkg: FSM state encoding, LCD_SPACE = 8'h20, LCD_COLS, LCD_LINE1_POS = 40, LCD_LAST_POS = 55.
//  One sub-module: lcd_rr_arbiter2 (2-way round-robin, req/grant + pointer); counters and mux stay inline.
// TESTING (bench models driver: ready drops 1 cycle after strobe, returns after N cycles)
//  1 Reset, ready=1: exactly 1 home then 56 writes, all 8'h20; busy falls after 56th ready return.
//  2 req0 sel=0 text="MD5 CRACKER 0.1 " -> ack0 one pulse; writes 0..15 = that string, 16..55 = 8'h20.
//  3 req0 and req1 same cycle in IDLE, rr_ptr=0 -> ack0 first, ack1 next cycle; one refresh shows both lines.
//  4 req1 raised during refresh -> no ack1 until IDLE; second refresh follows immediately after ack1.
//  5 Driver holds ready low 500 cycles after a write -> lcd_char stable, no extra strobes, sequence resumes.
//  6 rst_n low at pos 30 -> outputs 0 asynchronously; after release full blank refresh restarts from home.
//  7 (LCD_PERIODIC_REFRESH_EN, REFRESH_CYCLES=1000) no requests -> home strobe every 1000 cycles when idle.

Source files
------------

// File: rtl/lcd_pkg.sv
// Package: lcd_pkg
// Shared FSM encoding, LCD frame geometry constants and the frame character lookup.
package lcd_pkg;

    localparam int LCD_COLS      = 16;
    localparam int LCD_PAD_CHARS = 24;
    localparam int LCD_LINE1_POS = LCD_COLS + LCD_PAD_CHARS;
    localparam int LCD_LAST_POS  = LCD_LINE1_POS + LCD_COLS - 1;

    localparam logic [7:0]   LCD_SPACE      = 8'h20;
    localparam logic [127:0] LCD_BLANK_LINE = {LCD_COLS{LCD_SPACE}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOME_ISSUE,
        ST_HOME_WAIT,
        ST_SETTLE,
        ST_CHAR_ISSUE,
        ST_CHAR_GUARD,
        ST_CHAR_WAIT
    } lcd_state_e;

    // Column 0 sits in the top byte of a line; positions between the two lines are padding.
    function automatic logic [7:0] lcd_frame_char(
        input logic [127:0] line0,
        input logic [127:0] line1,
        input logic [5:0]   pos
    );
        logic [3:0] col;
        logic [7:0] ch;
        col = 4'd0;
        ch  = LCD_SPACE;
        if (pos < 6'(LCD_COLS)) begin
            col = pos[3:0];
            ch  = line0[{4'hF - col, 3'b000} +: 8];
        end else if (pos >= 6'(LCD_LINE1_POS) && pos <= 6'(LCD_LAST_POS)) begin
            col = 4'(pos - 6'(LCD_LINE1_POS));
            ch  = line1[{4'hF - col, 3'b000} +: 8];
        end
        return ch;
    endfunction

endpackage

// File: rtl/lcd_rr_arbiter2.sv
// Module: lcd_rr_arbiter2
// Two-way round-robin arbiter; the pointer only moves when both requesters contend.
module lcd_rr_arbiter2 (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    logic rr_ptr_q;
    logic rr_ptr_d;

    always_comb begin
        gnt0     = en & req0 & (~req1 | ~rr_ptr_q);
        gnt1     = en & req1 & (~req0 | rr_ptr_q);
        rr_ptr_d = rr_ptr_q;
        if (en & req0 & req1) begin
            rr_ptr_d = ~rr_ptr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/lcd_frame_scheduler.sv
// Module: lcd_frame_scheduler
// Arbitrates two line writers into a 2x16 frame buffer and replays the frame into the LCD driver.
// Optional periodic refresh is enabled by defining LCD_PERIODIC_REFRESH_EN.
module lcd_frame_scheduler
    import lcd_pkg::*;
#(
    parameter int HOME_SETTLE = 100000
`ifdef LCD_PERIODIC_REFRESH_EN
    ,
    parameter int REFRESH_CYCLES = 50000000
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0,
    input  logic         sel0,
    input  logic [127:0] text0,
    output logic         ack0,
    input  logic         req1,
    input  logic         sel1,
    input  logic [127:0] text1,
    output logic         ack1,
    input  logic         lcd_ready,
    output logic [7:0]   lcd_char,
    output logic         lcd_write_char,
    output logic         lcd_home,
    output logic         busy
);

    localparam int SETTLE_W = $clog2(HOME_SETTLE + 1);

    lcd_state_e          state_q, state_d;
    logic [5:0]          pos_q, pos_d;
    logic [SETTLE_W-1:0] cnt_q, cnt_d;
    logic                dirty_q, dirty_d;
    logic [127:0]        line0_q, line0_d;
    logic [127:0]        line1_q, line1_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;

    logic                gnt0, gnt1;
    logic                gnt_sel;
    logic [127:0]        gnt_text;
    logic                refresh_tick;

    // A requester whose ack is in flight still holds req this cycle, so mask it out.
    lcd_rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == ST_IDLE),
        .req0  (req0 & ~ack0_q),
        .req1  (req1 & ~ack1_q),
        .gnt0  (gnt0),
        .gnt1  (gnt1)
    );

`ifdef LCD_PERIODIC_REFRESH_EN
    localparam int REFRESH_W = $clog2(REFRESH_CYCLES);

    logic [REFRESH_W-1:0] refresh_cnt_q, refresh_cnt_d;

    always_comb begin
        refresh_tick  = (refresh_cnt_q == '0);
        refresh_cnt_d = refresh_tick ? REFRESH_W'(REFRESH_CYCLES - 1)
                                     : refresh_cnt_q - REFRESH_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt_q <= REFRESH_W'(REFRESH_CYCLES - 1);
        end else begin
            refresh_cnt_q <= refresh_cnt_d;
        end
    end
`else
    assign refresh_tick = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        pos_d          = pos_q;
        cnt_d          = cnt_q;
        dirty_d        = dirty_q | refresh_tick;
        line0_d        = line0_q;
        line1_d        = line1_q;
        ack0_d         = gnt0;
        ack1_d         = gnt1;
        lcd_home       = 1'b0;
        lcd_write_char = 1'b0;
        gnt_sel        = gnt1 ? sel1 : sel0;
        gnt_text       = gnt1 ? text1 : text0;

        if (gnt0 | gnt1) begin
            dirty_d = 1'b1;
            if (gnt_sel) begin
                line1_d = gnt_text;
            end else begin
                line0_d = gnt_text;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (!(gnt0 | gnt1) && dirty_q && lcd_ready) begin
                    state_d = ST_HOME_ISSUE;
                end
            end
            ST_HOME_ISSUE: begin
                lcd_home = 1'b1;
                dirty_d  = refresh_tick;
                pos_d    = 6'd0;
                cnt_d    = '0;
                state_d  = ST_HOME_WAIT;
            end
            // cnt == 0 marks the guard cycle before the driver has had a chance to drop ready.
            ST_HOME_WAIT: begin
                if (cnt_q == '0) begin
                    cnt_d = SETTLE_W'(1);
                end else if (lcd_ready) begin
                    cnt_d   = SETTLE_W'(HOME_SETTLE - 1);
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ST_CHAR_ISSUE;
                end else begin
                    cnt_d = cnt_q - SETTLE_W'(1);
                end
            end
            ST_CHAR_ISSUE: begin
                if (lcd_ready) begin
                    lcd_write_char = 1'b1;
                    state_d        = ST_CHAR_GUARD;
                end
            end
            ST_CHAR_GUARD: begin
                state_d = ST_CHAR_WAIT;
            end
            ST_CHAR_WAIT: begin
                if (lcd_ready) begin
                    if (pos_q == 6'(LCD_LAST_POS)) begin
                        state_d = ST_IDLE;
                    end else begin
                        pos_d   = pos_q + 6'd1;
                        state_d = ST_CHAR_ISSUE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        lcd_char = 8'h00;
        if (state_q inside {ST_CHAR_ISSUE, ST_CHAR_GUARD, ST_CHAR_WAIT}) begin
            lcd_char = lcd_frame_char(line0_q, line1_q, pos_q);
        end
    end

    assign ack0 = ack0_q;
    assign ack1 = ack1_q;
    assign busy = (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pos_q   <= 6'd0;
            cnt_q   <= '0;
            dirty_q <= 1'b1;
            line0_q <= LCD_BLANK_LINE;
            line1_q <= LCD_BLANK_LINE;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            cnt_q   <= cnt_d;
            dirty_q <= dirty_d;
            line0_q <= line0_d;
            line1_q <= line1_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
        end
    end

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// Testbench: tb_lcd_frame_scheduler
// Randomized requests and driver latencies checked against a frame-level reference model.
module tb_lcd_frame_scheduler;

    localparam int SETTLE_CYCLES = 20;
    localparam int FRAME_WRITES  = 56;
    localparam int WAIT_LIMIT    = 4000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0 = 1'b0, sel0 = 1'b0, req1 = 1'b0, sel1 = 1'b0;
    logic [127:0] text0 = '0, text1 = '0;
    logic         ack0, ack1;
    logic         lcd_ready = 1'b1;
    logic [7:0]   lcd_char;
    logic         lcd_write_char, lcd_home, busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the two visible lines and the expected round-robin pointer.
    logic [7:0] model_line [0:1][0:15];
    int         exp_ptr = 0;
    logic [7:0] exp_frame [0:FRAME_WRITES-1];

    int  cyc = 0;
    int  write_cnt = 0, home_cnt = 0, done_cnt = 0;
    int  home_time [$];
    bit  rdy_pend = 0, chk_busy = 0, force_long = 0, in_hold = 0, hold_seen = 0;
    int  lat = 1, lat_cnt = 0;
    logic [7:0] held_char = 8'h00;

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    lcd_frame_scheduler #(
        .HOME_SETTLE(SETTLE_CYCLES)
`ifdef LCD_PERIODIC_REFRESH_EN
        ,
        .REFRESH_CYCLES(1000)
`endif
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req0           (req0),
        .sel0           (sel0),
        .text0          (text0),
        .ack0           (ack0),
        .req1           (req1),
        .sel1           (sel1),
        .text1          (text1),
        .ack1           (ack1),
        .lcd_ready      (lcd_ready),
        .lcd_char       (lcd_char),
        .lcd_write_char (lcd_write_char),
        .lcd_home       (lcd_home),
        .busy           (busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] expectedChar(input int p);
        if (p < 16) return model_line[0][p];
        if (p >= 40 && p <= 55) return model_line[1][p-40];
        return 8'h20;
    endfunction

    task automatic modelWrite(input bit sel, input logic [127:0] t);
        for (int j = 0; j < 16; j++) model_line[sel][j] = t[8*(15-j) +: 8];
    endtask

    task automatic modelReset();
        for (int l = 0; l < 2; l++)
            for (int j = 0; j < 16; j++) model_line[l][j] = 8'h20;
        exp_ptr = 0;
    endtask

    function automatic logic [127:0] randText();
        logic [127:0] t;
        for (int j = 0; j < 16; j++) t[8*(15-j) +: 8] = 8'($urandom_range(33, 126));
        return t;
    endfunction

    // Driver model and protocol monitor: ready stays high for the guard cycle, then drops for N cycles.
    always @(negedge clk) begin
        if (chk_busy) begin
            checkOutput("busy_fall", busy, 0);
            chk_busy = 0;
        end
        if (lcd_home || lcd_write_char) begin
            checkOutput("strobe_ready", lcd_ready, 1);
            checkOutput("strobe_excl", lcd_home & lcd_write_char, 0);
        end
        if (lcd_home) begin
            home_cnt++;
            home_time.push_back(cyc);
            write_cnt = 0;
            for (int p = 0; p < FRAME_WRITES; p++) exp_frame[p] = expectedChar(p);
        end
        if (lcd_write_char) begin
            if (write_cnt < FRAME_WRITES)
                checkOutput($sformatf("char_pos%0d", write_cnt), lcd_char, exp_frame[write_cnt]);
            else
                checkOutput("extra_write", write_cnt, FRAME_WRITES - 1);
            write_cnt++;
            if (write_cnt == FRAME_WRITES) done_cnt++;
        end
        if (in_hold && !lcd_ready) begin
            checkOutput("hold_char", lcd_char, held_char);
        end
        if (rdy_pend) begin
            lcd_ready = 1'b0;
            rdy_pend  = 0;
            lat_cnt   = lat;
        end else if (!lcd_ready) begin
            lat_cnt--;
            if (lat_cnt <= 0) begin
                lcd_ready = 1'b1;
                in_hold   = 0;
                if (write_cnt == FRAME_WRITES) begin
                    checkOutput("busy_before_fall", busy, 1);
                    chk_busy = 1;
                end
            end
        end
        if (lcd_home || lcd_write_char) begin
            rdy_pend = 1;
            lat = $urandom_range(1, 4);
            if (force_long && lcd_write_char) begin
                lat        = 500;
                force_long = 0;
                in_hold    = 1;
                hold_seen  = 1;
                held_char  = lcd_char;
            end
        end
    end

    // Raises the selected requests together, collects acks, then advances the reference model.
    task automatic applyStimulus(input bit use0, input bit use1, input bit s0, input bit s1,
                                 input logic [127:0] t0, input logic [127:0] t1);
        int c0 = -1, c1 = -1, n0 = 0, n1 = 0;
        bit first;
        req0 = use0; sel0 = s0; text0 = t0;
        req1 = use1; sel1 = s1; text1 = t1;
        for (int i = 0; i < WAIT_LIMIT && (req0 || req1); i++) begin
            @(negedge clk);
            if (ack0) begin n0++; c0 = i; req0 = 1'b0; checkOutput("ack0_idle", busy, 0); end
            if (ack1) begin n1++; c1 = i; req1 = 1'b0; checkOutput("ack1_idle", busy, 0); end
        end
        @(negedge clk);
        if (ack0) n0++;
        if (ack1) n1++;
        checkOutput("ack0_pulses", n0, use0);
        checkOutput("ack1_pulses", n1, use1);
        checkOutput("home_after_ack", lcd_home, 1);
        req0 = 1'b0;
        req1 = 1'b0;
        if (use0 && use1) begin
            first = exp_ptr[0];
            checkOutput("rr_order", first ? (c0 - c1) : (c1 - c0), 1);
            if (first) begin modelWrite(s1, t1); modelWrite(s0, t0); end
            else       begin modelWrite(s0, t0); modelWrite(s1, t1); end
            exp_ptr ^= 1;
        end else if (use0) begin
            modelWrite(s0, t0);
        end else if (use1) begin
            modelWrite(s1, t1);
        end
    endtask

    task automatic waitRefresh(input string tag, input int home_base);
        int start_done;
        bit ok;
        start_done = done_cnt;
        ok = 0;
        for (int i = 0; i < WAIT_LIMIT; i++) begin
            @(negedge clk);
            if (done_cnt != start_done && !busy) begin
                ok = 1;
                break;
            end
        end
        checkOutput({tag, "_done"}, ok, 1);
        checkOutput({tag, "_homes"}, home_cnt - home_base, 1);
        checkOutput({tag, "_writes"}, write_cnt, FRAME_WRITES);
    endtask

    task automatic waitWrites(input int n);
        bit ok;
        ok = 0;
        for (int i = 0; i < WAIT_LIMIT; i++) begin
            @(negedge clk);
            if (write_cnt == n) begin
                ok = 1;
                break;
            end
        end
        checkOutput("wait_writes", ok, 1);
    endtask

    initial begin
        int hb, db;
        bit u0, u1;
        logic [127:0] msg;
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("rst_home", lcd_home, 0);
        checkOutput("rst_write", lcd_write_char, 0);
        checkOutput("rst_char", lcd_char, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_ack0", ack0, 0);
        checkOutput("rst_ack1", ack1, 0);

        $display("[TB] blank refresh after reset");
        hb = home_cnt;
        rst_n = 1'b1;
        waitRefresh("t1", hb);

        $display("[TB] single write to line 0");
        msg = "MD5 CRACKER 0.1 ";
        hb = home_cnt;
        applyStimulus(1, 0, 0, 0, msg, '0);
        waitRefresh("t2", hb);

        $display("[TB] simultaneous requests");
        hb = home_cnt;
        applyStimulus(1, 1, 0, 1, randText(), randText());
        waitRefresh("t3", hb);

        $display("[TB] request during refresh");
        hb = home_cnt;
        applyStimulus(1, 0, 1, 0, randText(), '0);
        waitWrites(10);
        db = done_cnt;
        hb = home_cnt;
        applyStimulus(0, 1, 0, 1, '0, randText());
        checkOutput("t4_waited", done_cnt - db, 1);
        waitRefresh("t4", hb);

        $display("[TB] long driver stall");
        hb = home_cnt;
        applyStimulus(0, 1, 0, 0, '0, randText());
        force_long = 1;
        waitRefresh("t5", hb);
        checkOutput("t5_hold_seen", hold_seen, 1);

        $display("[TB] reset mid-refresh");
        applyStimulus(1, 0, 1, 0, randText(), '0);
        waitWrites(30);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_home", lcd_home, 0);
        checkOutput("t6_write", lcd_write_char, 0);
        checkOutput("t6_char", lcd_char, 0);
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_ack0", ack0, 0);
        modelReset();
        repeat (2) @(negedge clk);
        hb = home_cnt;
        rst_n = 1'b1;
        waitRefresh("t6", hb);

        $display("[TB] randomized rounds");
        for (int r = 0; r < 8; r++) begin
            u0 = 1'($urandom_range(0, 1));
            u1 = 1'($urandom_range(0, 1));
            if (!u0 && !u1) u0 = 1;
            hb = home_cnt;
            applyStimulus(u0, u1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), randText(), randText());
            waitRefresh("rand", hb);
        end

`ifdef LCD_PERIODIC_REFRESH_EN
        $display("[TB] periodic refresh");
        begin
            int n;
            bit ok;
            n = home_time.size();
            ok = 0;
            for (int i = 0; i < 3000; i++) begin
                @(negedge clk);
                if (home_time.size() >= n + 2) begin
                    ok = 1;
                    break;
                end
            end
            checkOutput("t7_seen", ok, 1);
            if (ok) checkOutput("t7_period", home_time[n+1] - home_time[n], 1000);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
